// File: rtl/audio_pkg.sv
// Shared types and default sizes for the audio sample streaming block.
package audio_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned ADDR_W_DEF = 14;

  // Encoding is visible on the state output: 0=IDLE 1=RECORD 2=PREFETCH 3=PLAY.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECORD   = 2'd1,
    ST_PREFETCH = 2'd2,
    ST_PLAY     = 2'd3
  } state_e;

endpackage

// File: rtl/audio_sample_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port.
module audio_sample_ram #(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] rdata_q;

  // Store a stereo sample.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; a same-address write is forwarded (write-first).
  always_ff @(posedge clk) begin
    if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/audio_stream_ctrl.sv
// CODEC sample-port sequencer: passthrough, record to buffer, replay from buffer.
module audio_stream_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  input  logic              pass_en,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic              stop_req,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_len,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  state_e              state_q, state_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   wdl_q, wdl_d;
  logic [DATA_W-1:0]   wdr_q, wdr_d;
  logic [ADDR_W:0]     rec_len_q, rec_len_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [ADDR_W-1:0]   rp_q, rp_d;
  logic                pf_q, pf_d;

  logic                rd_fire;
  logic                wr_ok;
  logic                ram_we;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_raddr;
  logic [2*DATA_W-1:0] ram_rdata;

  // The RAM read register only changes on ram_re, so it serves as the
  // playback holding register; the write holdoff cycle hides its latency.
  audio_sample_ram #(
    .WIDTH  (2*DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (CLOCK_50),
    .we_i    (ram_we),
    .waddr_i (wp_q),
    .wdata_i ({readdata_left, readdata_right}),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Next-state, strobe and pointer decisions.
  always_comb begin
    rd_fire   = read_ready && !read_q;
    wr_ok     = write_ready && !write_q;
    state_d   = state_q;
    read_d    = rd_fire;
    write_d   = 1'b0;
    done_d    = 1'b0;
    wdl_d     = wdl_q;
    wdr_d     = wdr_q;
    rec_len_d = rec_len_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    pf_d      = pf_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = rp_q;
    case (state_q)
      ST_IDLE: begin
        if (pass_en && rd_fire && wr_ok) begin
          write_d = 1'b1;
          wdl_d   = readdata_left;
          wdr_d   = readdata_right;
        end
        if (rec_req) begin
          state_d = ST_RECORD;
          wp_d    = '0;
        end else if (play_req && (rec_len_q != '0)) begin
          state_d = ST_PREFETCH;
          rp_d    = '0;
          pf_d    = 1'b0;
        end
      end
      ST_RECORD: begin
        if (rd_fire) begin
          ram_we = 1'b1;
          wp_d   = wp_q + PTR_ONE;
        end
        if (rd_fire && ((wp_q == PTR_LAST) || stop_req)) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          rec_len_d = {1'b0, wp_q} + LEN_ONE;
        end else if (stop_req) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          rec_len_d = {1'b0, wp_q};
        end
      end
      ST_PREFETCH: begin
        ram_re = !pf_q;
        pf_d   = 1'b1;
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (pf_q) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (wr_ok) begin
          write_d   = 1'b1;
          wdl_d     = ram_rdata[2*DATA_W-1:DATA_W];
          wdr_d     = ram_rdata[DATA_W-1:0];
          rp_d      = rp_q + PTR_ONE;
          ram_re    = 1'b1;
          ram_raddr = rp_q + PTR_ONE;
          if ({1'b0, rp_q} == (rec_len_q - LEN_ONE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        if (stop_req) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      done_q    <= 1'b0;
      wdl_q     <= '0;
      wdr_q     <= '0;
      rec_len_q <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      pf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      write_q   <= write_d;
      done_q    <= done_d;
      wdl_q     <= wdl_d;
      wdr_q     <= wdr_d;
      rec_len_q <= rec_len_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      pf_q      <= pf_d;
    end
  end

  assign state           = state_q;
  assign read            = read_q;
  assign write           = write_q;
  assign done            = done_q;
  assign writedata_left  = wdl_q;
  assign writedata_right = wdr_q;
  assign rec_len         = rec_len_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Scoreboard bench for audio_stream_ctrl with a small buffer (8 entries).
module tb_audio_stream_ctrl;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 3;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          read_ready, write_ready;
  logic [DW-1:0] readdata_left, readdata_right;
  logic          read, write;
  logic [DW-1:0] writedata_left, writedata_right;
  logic          pass_en, rec_req, play_req, stop_req;
  logic [1:0]    state;
  logic [AW:0]   rec_len;
  logic          done;

  audio_stream_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .pass_en         (pass_en),
    .rec_req         (rec_req),
    .play_req        (play_req),
    .stop_req        (stop_req),
    .state           (state),
    .rec_len         (rec_len),
    .done            (done)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  logic [47:0] adc_q[$];
  logic [47:0] exp_q[$];
  int unsigned n_chk = 0, n_fail = 0;
  int unsigned n_rd = 0, n_wr = 0, n_done = 0, cyc = 0, first_wr_cyc = 0;
  int unsigned base_rd, base_wr, base_done, req_cyc;
  logic        prev_rd = 1'b0, prev_wr = 1'b0, pt_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adc_refresh();
    read_ready = (adc_q.size() != 0);
    if (adc_q.size() != 0) {readdata_left, readdata_right} = adc_q[0];
  endtask

  task automatic adc_push(input logic [23:0] l, input logic [23:0] r);
    adc_q.push_back({l, r});
    adc_refresh();
  endtask

  // One cycle: observe outputs at the falling edge, update ADC model and scoreboard.
  task automatic tick();
    logic [47:0] e;
    @(negedge CLOCK_50);
    cyc++;
    if (write) begin
      check("wr_holdoff", prev_wr, 0);
      if (pt_chk) check("pt_rd_with_wr", read, 1);
      check("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wdata_l", writedata_left, e[47:24]);
        check("wdata_r", writedata_right, e[23:0]);
      end
      if (first_wr_cyc == 0) first_wr_cyc = cyc;
      n_wr++;
    end
    if (read) begin
      check("rd_holdoff", prev_rd, 0);
      if (pt_chk) check("pt_wr_with_rd", write, 1);
      if (adc_q.size() != 0) void'(adc_q.pop_front());
      n_rd++;
    end
    if (done) n_done++;
    prev_rd = read;
    prev_wr = write;
    adc_refresh();
  endtask

  task automatic drain_adc(input int unsigned budget);
    for (int unsigned k = 0; k < budget && adc_q.size() != 0; k++) tick();
    check("adc_drain", adc_q.size(), 0);
  endtask

  task automatic drain_exp(input int unsigned budget);
    for (int unsigned k = 0; k < budget && exp_q.size() != 0; k++) tick();
    check("exp_drain", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; pass_en = 1'b0; rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
    write_ready = 1'b1; read_ready = 1'b0; readdata_left = '0; readdata_right = '0;

    // Reset values with both FIFOs ready, then alternate-cycle ADC drain.
    for (int i = 0; i < 6; i++) adc_push(24'h5A5A00 + 24'(i), 24'hA5A500 + 24'(i));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_read", read, 0);
      check("rst_write", write, 0);
      check("rst_done", done, 0);
      check("rst_state", state, 0);
      check("rst_rec_len", rec_len, 0);
      check("rst_wdata", {writedata_left, writedata_right}, 0);
    end
    reset = 1'b0;
    base_rd = n_rd; base_wr = n_wr;
    repeat (8) tick();
    check("rst_rd_alternate", n_rd - base_rd, 4);
    drain_adc(10);
    check("idle_no_pass_writes", n_wr - base_wr, 0);

    // play_req with an empty buffer is ignored.
    play_req = 1'b1; tick(); play_req = 1'b0;
    check("play_empty_state", state, 0);
    tick();
    check("play_empty_state2", state, 0);

    // Passthrough.
    pass_en = 1'b1; pt_chk = 1'b1; base_wr = n_wr;
    for (int i = 0; i < 4; i++) begin
      adc_push(24'h123456, 24'hABCDEF);
      exp_q.push_back({24'h123456, 24'hABCDEF});
    end
    for (int i = 0; i < 2; i++) begin
      adc_push(24'h0F0000 + 24'(i), 24'h00F000 + 24'(i));
      exp_q.push_back({24'h0F0000 + 24'(i), 24'h00F000 + 24'(i)});
    end
    drain_exp(40);
    check("pt_writes", n_wr - base_wr, 6);
    tick(); tick();
    pt_chk = 1'b0; pass_en = 1'b0;

    // Record five samples then stop.
    base_wr = n_wr; base_done = n_done;
    rec_req = 1'b1; tick(); rec_req = 1'b0;
    check("rec_state", state, 1);
    for (int i = 0; i < 5; i++) adc_push(24'(i), ~24'(i));
    drain_adc(40);
    tick(); tick();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    check("rec_done", done, 1);
    check("rec_exit_state", state, 0);
    check("rec_len5", rec_len, 5);
    tick();
    check("rec_done_one_cycle", done, 0);
    check("rec_done_count", n_done - base_done, 1);
    check("rec_no_writes", n_wr - base_wr, 0);

    // Play back the five samples.
    base_wr = n_wr; base_done = n_done; first_wr_cyc = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back({24'(i), ~24'(i)});
    play_req = 1'b1; tick(); req_cyc = cyc; play_req = 1'b0;
    drain_exp(40);
    check("pb_first_latency", (first_wr_cyc + 1) >= (req_cyc + 3), 1);
    tick(); tick();
    check("pb_writes", n_wr - base_wr, 5);
    check("pb_done_count", n_done - base_done, 1);
    check("pb_state", state, 0);
    check("pb_rec_len", rec_len, 5);

    // rec_req and play_req together: record wins.
    rec_req = 1'b1; play_req = 1'b1; tick(); rec_req = 1'b0; play_req = 1'b0;
    check("both_req_state", state, 1);
    for (int i = 0; i < 2; i++) adc_push(24'h00A000 + 24'(i), 24'h00B000 + 24'(i));
    drain_adc(20);
    tick(); tick();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    check("both_rec_len", rec_len, 2);
    check("both_state", state, 0);

    // Reset while in PLAY.
    write_ready = 1'b0;
    play_req = 1'b1; tick(); play_req = 1'b0;
    tick(); tick();
    check("rstplay_in_play", state, 3);
    base_done = n_done;
    write_ready = 1'b1; reset = 1'b1;
    tick();
    check("rstplay_write", write, 0);
    check("rstplay_state", state, 0);
    check("rstplay_rec_len", rec_len, 0);
    check("rstplay_done", done, 0);
    reset = 1'b0;
    repeat (4) tick();
    check("rstplay_no_done", n_done - base_done, 0);

    // Full buffer: ten samples offered, eight stored.
    base_done = n_done; base_rd = n_rd;
    rec_req = 1'b1; tick(); rec_req = 1'b0;
    check("full_state", state, 1);
    for (int i = 0; i < 10; i++) adc_push(24'h000100 + 24'(i), 24'h000200 + 24'(i));
    drain_adc(60);
    tick(); tick();
    check("full_rec_len", rec_len, 8);
    check("full_state_idle", state, 0);
    check("full_done_count", n_done - base_done, 1);
    check("full_reads", n_rd - base_rd, 10);
    base_wr = n_wr; base_done = n_done;
    for (int i = 0; i < 8; i++) exp_q.push_back({24'h000100 + 24'(i), 24'h000200 + 24'(i)});
    play_req = 1'b1; tick(); play_req = 1'b0;
    drain_exp(60);
    tick(); tick();
    check("full_pb_writes", n_wr - base_wr, 8);
    check("full_pb_done", n_done - base_done, 1);
    check("full_pb_state", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
